// File: rtl/inst_cache_if.sv
// Refill bus between the instruction cache and the backing instruction memory.
// The cache is the master: it issues word requests and receives data.
interface inst_cache_if #(
  parameter int XLEN = 32
);
  logic            mem_req;
  logic [XLEN-1:0] mem_addr;
  logic            mem_ready;
  logic [XLEN-1:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ready, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ready, output mem_rdata);
endinterface

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache with whole-line refill.
// Hits return combinationally; misses stall the core (inst_valid=0) while the
// line is fetched one word per mem_ready beat.
// Optional build macro ICACHE_STATS_EN adds hit_count / miss_count outputs.
//
// state | meaning
// IDLE  | lookup on inst_addr; hit -> inst_valid, miss -> latch line, go FILL
// FILL  | request words base+4*cnt until last beat, then write tag and return
module inst_cache #(
  parameter int LINES          = 8,
  parameter int WORDS_PER_LINE = 4,
  parameter int XLEN           = 32
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic [XLEN-1:0] inst_addr,
  output logic [XLEN-1:0] inst,
  output logic            inst_valid,
  input  logic            flush,
  inst_cache_if.master    bus
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]     hit_count,
  output logic [31:0]     miss_count
`endif
);

  localparam int OFF   = $clog2(WORDS_PER_LINE);
  localparam int IDX   = $clog2(LINES);
  localparam int TAGW  = XLEN - IDX - OFF - 2;
  localparam int LINEW = XLEN - OFF - 2;

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state_q, state_d;
  logic [LINES-1:0]  valid_q;
  logic [TAGW-1:0]   tag_q  [LINES];
  logic [XLEN-1:0]   data_q [LINES*WORDS_PER_LINE];
  logic [LINEW-1:0]  line_q;
  logic [OFF-1:0]    cnt_q;
  logic              flush_pend_q;

  logic [OFF-1:0]    req_off;
  logic [IDX-1:0]    req_idx;
  logic [TAGW-1:0]   req_tag;
  logic [IDX-1:0]    fill_idx;
  logic [TAGW-1:0]   fill_tag;
  logic              hit;
  logic              start_fill;
  logic              beat;
  logic              last_beat;
  logic [1:0]        unused_lsb;

  assign req_off    = inst_addr[OFF+1:2];
  assign req_idx    = inst_addr[IDX+OFF+1:OFF+2];
  assign req_tag    = inst_addr[XLEN-1:IDX+OFF+2];
  assign fill_idx   = line_q[IDX-1:0];
  assign fill_tag   = line_q[LINEW-1:IDX];
  assign hit        = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign unused_lsb = inst_addr[1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_b) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state, lookup outputs and refill request.
  always_comb begin
    state_d      = state_q;
    inst         = '0;
    inst_valid   = 1'b0;
    bus.mem_req  = 1'b0;
    bus.mem_addr = '0;
    start_fill   = 1'b0;
    beat         = 1'b0;
    last_beat    = 1'b0;
    case (state_q)
      IDLE: begin
        if (hit) begin
          inst_valid = 1'b1;
          inst       = data_q[{req_idx, req_off}];
        end else if (!flush) begin
          start_fill = 1'b1;
          state_d    = FILL;
        end
      end
      FILL: begin
        bus.mem_req  = 1'b1;
        bus.mem_addr = {line_q, cnt_q, 2'b00};
        if (bus.mem_ready) begin
          beat = 1'b1;
          if (&cnt_q) begin
            last_beat = 1'b1;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Valid bits, latched line address, beat counter and deferred flush.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      valid_q      <= '0;
      line_q       <= '0;
      cnt_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      if (start_fill) begin
        line_q       <= {req_tag, req_idx};
        cnt_q        <= '0;
        flush_pend_q <= 1'b0;
      end
      if (state_q == IDLE && flush) valid_q <= '0;
      if (state_q == FILL && flush) flush_pend_q <= 1'b1;
      if (beat) cnt_q <= cnt_q + 1'b1;
      if (last_beat) begin
        // A flush seen at any point of the fill, including the last beat,
        // leaves the freshly filled line invalid.
        if (flush_pend_q || flush) valid_q <= '0;
        else                       valid_q[fill_idx] <= 1'b1;
        flush_pend_q <= 1'b0;
      end
    end
  end

  // Data and tag arrays; contents are meaningless until their valid bit is set.
  always_ff @(posedge clk) begin
    if (beat)      data_q[{fill_idx, cnt_q}] <= bus.mem_rdata;
    if (last_beat) tag_q[fill_idx]           <= fill_tag;
  end

`ifdef ICACHE_STATS_EN
  // Hit cycles and miss transitions, free-running and wrapping.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (state_q == IDLE && hit) hit_count  <= hit_count + 32'd1;
      if (start_fill)             miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Randomized bench for inst_cache against a line-level model of the cache
// contents (valid/tag per line); memory word at A is A+0x100.
module tb_inst_cache;
  logic        clk = 1'b0;
  logic        rst_b = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] inst_addr = '0;
  logic [31:0] inst;
  logic        inst_valid;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int total = 0;
  int bad   = 0;

  bit          ref_valid [8];
  logic [24:0] ref_tag   [8];
  int          exp_hits  = 0;
  int          exp_miss  = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b00} + 32'h100;
  endfunction

  inst_cache_if #(.XLEN(32)) bus();
  assign bus.mem_rdata = mem_word(bus.mem_addr);

  inst_cache #(.LINES(8), .WORDS_PER_LINE(4), .XLEN(32)) dut (
    .clk       (clk),
    .rst_b     (rst_b),
    .inst_addr (inst_addr),
    .inst      (inst),
    .inst_valid(inst_valid),
    .flush     (flush),
    .bus       (bus)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
  endtask

  function automatic bit model_hit(input logic [31:0] a);
    return ref_valid[a[6:4]] && (ref_tag[a[6:4]] == a[31:7]);
  endfunction

  task automatic chk_stats(input string tag);
`ifdef ICACHE_STATS_EN
    chk({tag, "_hits"}, hit_count, 32'(exp_hits));
    chk({tag, "_miss"}, miss_count, 32'(exp_miss));
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // Fetch address a until it hits; fills use mem_ready every rdy_every-th
  // cycle and, on the first fill only, flush is raised at FILL cycle flush_cyc.
  // Entered and left at posedge+1.
  task automatic do_fetch(input logic [31:0] a, input int rdy_every, input int flush_cyc);
    logic [31:0] base;
    bit pend, rdy, done;
    int beat_n, cyc;
    base = {a[31:4], 4'h0};
    done = 1'b0;
    inst_addr = a;
    flush = 1'b0;
    bus.mem_ready = 1'b0;
    for (int pass = 0; pass < 3 && !done; pass++) begin
      @(negedge clk);
      if (model_hit(a)) begin
        chk("hit_valid", 32'(inst_valid), 32'd1);
        chk("hit_inst", inst, mem_word(a));
        chk("hit_req", 32'(bus.mem_req), 32'd0);
        exp_hits++;
        done = 1'b1;
        @(posedge clk); #1;
      end else begin
        chk("miss_valid", 32'(inst_valid), 32'd0);
        chk("miss_inst", inst, 32'd0);
        exp_miss++;
        @(posedge clk); #1;
        pend = 1'b0;
        beat_n = 0;
        cyc = 0;
        while (beat_n < 4 && cyc < 200) begin
          rdy = ((cyc + 1) % rdy_every) == 0;
          bus.mem_ready = rdy;
          flush = (pass == 0) && (cyc == flush_cyc);
          if (flush) pend = 1'b1;
          @(negedge clk);
          chk("fill_req", 32'(bus.mem_req), 32'd1);
          chk("fill_addr", bus.mem_addr, base + 32'(4 * beat_n));
          chk("fill_valid", 32'(inst_valid), 32'd0);
          @(posedge clk); #1;
          if (rdy) beat_n++;
          cyc++;
        end
        bus.mem_ready = 1'b0;
        flush = 1'b0;
        chk("fill_cycles", 32'(cyc), 32'(4 * rdy_every));
        ref_tag[a[6:4]] = a[31:7];
        if (pend) model_clear();
        else      ref_valid[a[6:4]] = 1'b1;
      end
    end
    chk("fetch_done", 32'(done), 32'd1);
  endtask

  // One-cycle flush while in IDLE on the current inst_addr.
  task automatic do_flush();
    bit h;
    h = model_hit(inst_addr);
    flush = 1'b1;
    @(negedge clk);
    chk("flush_valid", 32'(inst_valid), 32'(h));
    chk("flush_req", 32'(bus.mem_req), 32'd0);
    if (h) exp_hits++;
    @(posedge clk); #1;
    flush = 1'b0;
    model_clear();
  endtask

  initial begin
    logic [31:0] a;
    int re, fc;
    bus.mem_ready = 1'b0;
    model_clear();

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(bus.mem_req), 32'd0);
    chk("rst_addr", bus.mem_addr, 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk_stats("rst");
    rst_b = 1'b1;

    do_fetch(32'h00, 1, -1);          // cold miss, 4 back-to-back beats
    do_fetch(32'h08, 1, -1);          // same-line hit
    do_fetch(32'h80, 1, -1);          // conflict on index 0
    do_fetch(32'h00, 1, -1);          // evicted, misses again
    do_fetch(32'h40, 4, -1);          // slow memory, addr held 4 cycles
    do_fetch(32'h20, 1, 2);           // flush mid-fill -> refill
    do_fetch(32'h08, 1, -1);
    do_flush();
    do_fetch(32'h08, 1, -1);          // misses after IDLE flush
    chk_stats("mid");

    // Reset during beat 2 of a fill.
    inst_addr = 32'h00;
    do_flush();
    @(negedge clk);
    chk("r6_miss", 32'(inst_valid), 32'd0);
    @(posedge clk); #1;
    bus.mem_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst_b = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b1;
    bus.mem_ready = 1'b0;
    chk("r6_req", 32'(bus.mem_req), 32'd0);
    chk("r6_valid", 32'(inst_valid), 32'd0);
    model_clear();
    exp_hits = 0;
    exp_miss = 0;
    chk_stats("r6");
    do_fetch(32'h00, 1, -1);

    // Randomized fetches over a small address space to mix hits and conflicts.
    for (int n = 0; n < 60; n++) begin
      a = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 7)) << 4) |
          (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      re = int'($urandom_range(1, 3));
      fc = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 4 * re - 1)) : -1;
      do_fetch(a, re, fc);
      if ($urandom_range(0, 7) == 0) do_flush();
    end
    chk_stats("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
